// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-requester round-robin arbiter for a single-port data RAM
// Each transaction runs IDLE -> ACCESS -> ACK, so the RAM serves one access per three cycles.
module data_ram_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [1:0]          iReq,
    input  logic [1:0]          iWrEn,
    input  logic [5:0]          iFunct3,
    input  logic [2*DATA_W-1:0] iAddr,
    input  logic [2*DATA_W-1:0] iWrData,
    output logic [1:0]          oAck,
    output logic [DATA_W-1:0]   oRdData,
    output logic [1:0]          oGrant,
    output logic                oBusy,
    output logic                oData_WrEn,
    output logic [2:0]          oFunct3,
    output logic [DATA_W-1:0]   oData_Addr,
    output logic [DATA_W-1:0]   oData_WrData,
    input  logic [DATA_W-1:0]   iData_RdData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                r_last;
    logic                r_idx;
    logic                r_wr_en;
    logic [2:0]          r_funct3;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [DATA_W-1:0]   r_rd_data;

    logic                win;
    logic                latch;
    logic [1:0]          idx_onehot;

    // On a tie the requester that did not finish last wins.
    always_comb begin
        win = 1'b0;
        case (iReq)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ~r_last;
        endcase
    end

    assign latch = (state == IDLE) && (iReq != 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iReq != 2'b00) state_nxt = ACCESS;
            ACCESS:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_last    <= 1'b1;
            r_idx     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_rd_data <= '0;
        end else begin
            if (latch) begin
                r_idx     <= win;
                r_wr_en   <= win ? iWrEn[1] : iWrEn[0];
                r_funct3  <= win ? iFunct3[5:3] : iFunct3[2:0];
                r_addr    <= win ? iAddr[2*DATA_W-1:DATA_W] : iAddr[DATA_W-1:0];
                r_wr_data <= win ? iWrData[2*DATA_W-1:DATA_W] : iWrData[DATA_W-1:0];
            end
            // Captured on stores too; the RAM output is simply ignored by the writer.
            if (state == ACCESS) begin
                r_rd_data <= iData_RdData;
            end
            if (state == ACK) begin
                r_last <= r_idx;
            end
        end
    end

    assign idx_onehot = r_idx ? 2'b10 : 2'b01;

    always_comb begin
        oAck       = 2'b00;
        oGrant     = 2'b00;
        oData_WrEn = 1'b0;
        if (state != IDLE) begin
            oGrant = idx_onehot;
        end
        if (state == ACCESS) begin
            oData_WrEn = r_wr_en;
        end
        if (state == ACK) begin
            oAck = idx_onehot;
        end
    end

    assign oBusy        = (state != IDLE);
    assign oFunct3      = r_funct3;
    assign oData_Addr   = r_addr;
    assign oData_WrData = r_wr_data;
    assign oRdData      = r_rd_data;

endmodule

// File: doc/data_ram_arbiter.md
DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the address, write-data and read-data buses.
REQ-002 The block SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port iRst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port iReq, input, 2 bits: bit m is the request from requester m (m=0 core, m=1 DMA/loader).
REQ-005 The block SHALL have port iWrEn, input, 2 bits: bit m is requester m's write enable (1=store, 0=load).
REQ-006 The block SHALL have port iFunct3, input, 6 bits: requester m's access size/sign code in bits [3m+2:3m].
REQ-007 The block SHALL have port iAddr, input, 2*DATA_W bits: requester m's byte address in slice m.
REQ-008 The block SHALL have port iWrData, input, 2*DATA_W bits: requester m's store data in slice m.
REQ-009 The block SHALL have port oAck, output, 2 bits: bit m is a one-cycle completion pulse to requester m.
REQ-010 The block SHALL have port oRdData, output, DATA_W bits: load data, valid while any oAck bit is high.
REQ-011 The block SHALL have port oGrant, output, 2 bits: one-hot owner of the RAM, zero when idle.
REQ-012 The block SHALL have port oBusy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port oData_WrEn, output, 1 bit: RAM write strobe.
REQ-014 The block SHALL have port oFunct3, output, 3 bits: RAM size/sign code.
REQ-015 The block SHALL have port oData_Addr, output, DATA_W bits: RAM address.
REQ-016 The block SHALL have port oData_WrData, output, DATA_W bits: RAM write data.
REQ-017 The block SHALL have port iData_RdData, input, DATA_W bits: RAM read data, combinational from oData_Addr/oFunct3.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE -> ACCESS -> ACK -> IDLE, with one cycle spent in each of ACCESS and ACK.
REQ-019 In IDLE with iReq != 0, the block SHALL select a winner, latch that requester's iWrEn/iFunct3/iAddr/iWrData slice plus its index, and enter ACCESS on the next edge.
REQ-020 Winner selection SHALL be round-robin: with one request pending that requester wins; with both pending, the requester other than rLast wins.
REQ-021 In ACCESS, oData_WrEn SHALL equal the latched write enable; in every other state oData_WrEn SHALL be 0.
REQ-022 oFunct3, oData_Addr and oData_WrData SHALL always drive the latched values, which change only on a new IDLE latch.
REQ-023 At the end of ACCESS, iData_RdData SHALL be captured into the read register for both loads and stores, and oRdData SHALL drive that register.
REQ-024 In ACK, oAck SHALL pulse for the latched index only, and rLast SHALL be updated to that index.
REQ-025 oGrant SHALL be one-hot for the latched index in ACCESS and ACK, and 0 in IDLE.
REQ-026 Latency SHALL be fixed: a request sampled in IDLE at edge N gives ACCESS in cycle N+1 and oAck in cycle N+2.
REQ-027 Peak throughput SHALL be one transaction per 3 cycles.
REQ-028 iReq SHALL be sampled only in IDLE; requests arriving during ACCESS or ACK wait until the next IDLE.
REQ-029 Requesters hold their request until oAck; a requester that drops iReq after latching SHALL still receive its oAck, and the access SHALL complete.
REQ-030 With both requests held continuously, grants SHALL strictly alternate, so that neither requester waits more than one transaction.

Reset
REQ-031 While iRst is high, the FSM SHALL be IDLE and rLast SHALL be 1, so requester 0 wins the first tie.
REQ-032 While iRst is high, oAck, oGrant, oBusy and oData_WrEn SHALL be 0, and oFunct3, oData_Addr, oData_WrData, oRdData and the latched registers SHALL be 0, all asynchronously.
REQ-033 Reset asserted during ACCESS or ACK SHALL abort the transaction, drop oData_WrEn immediately, and produce no oAck.

Verification
REQ-034 Single load: only iReq[0]=1, iWrEn[0]=0, addr 0x10, RAM returns 0xDEADBEEF -> oGrant=01 in cycles N+1..N+2, oData_WrEn=0, oAck=01 in N+2, oRdData=0xDEADBEEF.
REQ-035 Single store: only requester 1, addr 0x20, data 0x12345678, funct3=010 -> oData_WrEn=1 for exactly cycle N+1 with addr 0x20, data 0x12345678, oFunct3=010; oAck=10 in N+2.
REQ-036 Tie after reset: both iReq held high for 4 transactions -> grant order 0,1,0,1 and oAck pulses at cycles N+2, N+5, N+8, N+11.
REQ-037 Late request: iReq[1] rises during requester 0's ACCESS cycle -> it is not latched until the following IDLE, and its oAck comes 3 cycles after requester 0's oAck.
REQ-038 Reset mid-store: iRst pulsed during ACCESS of a store -> oData_WrEn falls in the same cycle, no oAck, and after release requester 0 wins the next tie.
REQ-039 Dropped request: iReq[0] deasserted in cycle N+1 -> oAck[0] still pulses in cycle N+2.
